// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Groups the serial line, the per-frame configuration and the received-byte
// outputs of the UART receiver into one bundle.
//
// Signals:
//   RX_IN        serial line, idle high, already synchronous to the receiver clock
//   PAR_EN       1 = a parity bit follows the data bits
//   PAR_TYP      0 = even parity, 1 = odd parity
//   Prescale     oversampling ratio (8, 16 or 32 clocks per bit)
//   P_DATA       last correctly received byte
//   data_valid   one-cycle pulse, P_DATA updated in the same cycle
//   parity_error one-cycle pulse, parity bit did not match the data
//   stop_error   one-cycle pulse, stop bit was sampled low
//
// Modports:
//   master  drives the line and configuration, observes the results
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output RX_IN,
    output PAR_EN,
    output PAR_TYP,
    output Prescale,
    input  P_DATA,
    input  data_valid,
    input  parity_error,
    input  stop_error
  );

  modport slave (
    input  RX_IN,
    input  PAR_EN,
    input  PAR_TYP,
    input  Prescale,
    output P_DATA,
    output data_valid,
    output parity_error,
    output stop_error
  );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling asynchronous serial receiver. A frame is a low start bit,
// DATA_WIDTH data bits LSB first, an optional parity bit and one high stop
// bit. Each bit lasts Prescale clocks; the line is sampled three times around
// the bit centre and the bit value is the majority of those samples. A good
// frame produces a one-cycle data_valid pulse with P_DATA updated in the same
// cycle; a bad frame produces parity_error and/or stop_error pulses instead
// and leaves P_DATA untouched.
//
// Ports:
//   CLK     oversampling clock (baud rate x Prescale)
//   RST     asynchronous active-low reset
//   io_bus  uart_rx_if slave modport: RX_IN, PAR_EN, PAR_TYP, Prescale in;
//           P_DATA, data_valid, parity_error, stop_error out
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_rx_if.slave   io_bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  // Frame configuration captured at start detection and held for the frame.
  logic [5:0]            r_presc;
  logic                  r_par_en;
  logic                  r_par_typ;

  // First two oversamples of the current bit and the voted bit value.
  logic                  r_samp0;
  logic                  r_samp1;
  logic                  r_bit;
  logic                  r_par_err;

  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_parity_error;
  logic                  r_stop_error;

  logic                  w_rx;
  logic [5:0]            w_half;
  logic                  w_wrap;
  logic                  w_samp0;
  logic                  w_samp1;
  logic                  w_samp2;
  logic                  w_decide;
  logic                  w_vote;
  logic                  w_presc_ok;
  logic                  w_exp_par;
  logic                  w_last_bit;

  assign w_rx       = io_bus.RX_IN;
  assign w_half     = r_presc >> 1;
  assign w_wrap     = (r_edge_cnt == (r_presc - 6'd1));
  assign w_samp0    = (r_edge_cnt == (w_half - 6'd1));
  assign w_samp1    = (r_edge_cnt == w_half);
  assign w_samp2    = (r_edge_cnt == (w_half + 6'd1));
  assign w_decide   = (r_edge_cnt == (w_half + 6'd2));
  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // The third sample is taken straight from the line so the vote is ready
  // one edge after the bit centre window closes.
  assign w_vote = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);

  assign w_presc_ok = (io_bus.Prescale == 6'd8) ||
                      (io_bus.Prescale == 6'd16) ||
                      (io_bus.Prescale == 6'd32);

  // Odd parity is even parity inverted.
  assign w_exp_par = (^r_shift) ^ r_par_typ;

  assign io_bus.P_DATA       = r_p_data;
  assign io_bus.data_valid   = r_data_valid;
  assign io_bus.parity_error = r_parity_error;
  assign io_bus.stop_error   = r_stop_error;

  // Receiver FSM, oversampling counters and registered result outputs.
  // The edge counter runs in every non-idle state and wraps on each bit
  // boundary; states only advance on that wrap, except for a false start,
  // which is abandoned as soon as the start-bit vote is known.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= IDLE;
      r_edge_cnt     <= 6'd0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_presc        <= 6'd0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_samp0        <= 1'b0;
      r_samp1        <= 1'b0;
      r_bit          <= 1'b0;
      r_par_err      <= 1'b0;
      r_p_data       <= '0;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
    end else begin
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;

      if (r_state != IDLE) begin
        if (w_samp0) r_samp0 <= w_rx;
        if (w_samp1) r_samp1 <= w_rx;
        if (w_samp2) r_bit   <= w_vote;
        r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
      end

      unique case (r_state)
        IDLE: begin
          // The detection cycle counts as edge 0 of the start bit. An
          // unsupported ratio simply leaves the receiver waiting.
          if (!w_rx && w_presc_ok) begin
            r_state    <= START;
            r_edge_cnt <= 6'd1;
            r_presc    <= io_bus.Prescale;
            r_par_en   <= io_bus.PAR_EN;
            r_par_typ  <= io_bus.PAR_TYP;
            r_par_err  <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end

        START: begin
          if (w_decide && r_bit) begin
            r_state    <= IDLE;
            r_edge_cnt <= 6'd0;
          end else if (w_wrap) begin
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_wrap) begin
            r_shift <= {r_bit, r_shift[DATA_WIDTH-1:1]};
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (w_wrap) begin
            r_par_err <= (r_bit != w_exp_par);
            r_state   <= STOP;
          end
        end

        STOP: begin
          // Result is issued on the last edge of the stop bit so the next
          // cycle is already idle and can accept a back-to-back start bit.
          if (w_wrap) begin
            r_state        <= IDLE;
            r_parity_error <= r_par_err;
            r_stop_error   <= ~r_bit;
            if (!r_par_err && r_bit) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Builds serial waveforms cycle by cycle from frame descriptions, drives them
// into uart_rx and compares every result pulse (cycle, data, error kind)
// against a frame-level reference model. Time index k below means "value
// seen after posedge k of the phase", so a result that a consumer sees at
// edge T0 + N*P is recorded at index T0 + N*P - 1.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic clk = 1'b0;
  logic rstN;

  int assertions = 0;
  int failures   = 0;

  uart_rx_if #(.DATA_WIDTH(8)) busIf ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK    (clk),
    .RST    (rstN),
    .io_bus (busIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rx;
    logic       rstN;
    logic       parEn;
    logic       parTyp;
    logic [5:0] presc;
  } cycle_t;

  typedef struct {
    logic [7:0] data;
    bit         parEn;
    bit         parTyp;
    int         presc;
    bit         parFlip;
    logic       stopBit;
    int         noiseBit;
    int         noiseEdgeA;
    int         noiseEdgeB;
    bit         cfgScramble;
    int         rstAt;
  } frame_t;

  cycle_t     wave[$];
  int         expDvTime[$];
  logic [7:0] expDvData[$];
  int         expPeTime[$];
  int         expSeTime[$];
  logic [7:0] expErrData[$];
  int         obsDvTime[$];
  logic [7:0] obsDvData[$];
  int         obsPeTime[$];
  int         obsSeTime[$];
  logic [7:0] obsErrData[$];
  logic [7:0] modelData;

  // A plain frame with no noise, no corruption and no reset.
  function automatic frame_t mkFrame(input logic [7:0] data, input bit parEn,
                                     input bit parTyp, input int presc);
    frame_t f;
    f.data        = data;
    f.parEn       = parEn;
    f.parTyp      = parTyp;
    f.presc       = presc;
    f.parFlip     = 1'b0;
    f.stopBit     = 1'b1;
    f.noiseBit    = -1;
    f.noiseEdgeA  = -1;
    f.noiseEdgeB  = -1;
    f.cfgScramble = 1'b0;
    f.rstAt       = -1;
    return f;
  endfunction

  task automatic clearPhase();
    wave.delete();
    expDvTime.delete();
    expDvData.delete();
    expPeTime.delete();
    expSeTime.delete();
    expErrData.delete();
  endtask

  task automatic appendIdle(input int n, input int presc);
    cycle_t c;
    c.rx     = 1'b1;
    c.rstN   = 1'b1;
    c.parEn  = 1'b0;
    c.parTyp = 1'b0;
    c.presc  = 6'(presc);
    repeat (n) wave.push_back(c);
  endtask

  // Appends the frame's waveform and the result the receiver must produce.
  task automatic appendFrame(input frame_t f);
    int         p;
    int         start;
    int         nBits;
    int         ones;
    logic       bits[$];
    logic       recv[$];
    logic [7:0] d;
    logic       recvPar;
    logic       recvStop;
    bit         parErr;
    bit         stopErr;
    cycle_t     c;

    p     = f.presc;
    start = wave.size();
    nBits = 10 + (f.parEn ? 1 : 0);

    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.parEn) bits.push_back((^f.data) ^ f.parTyp ^ f.parFlip);
    bits.push_back(f.stopBit);

    for (int b = 0; b < nBits; b++) begin
      for (int e = 0; e < p; e++) begin
        int idx;
        idx  = b * p + e;
        c.rx = bits[b];
        if (b == f.noiseBit && (e == f.noiseEdgeA || e == f.noiseEdgeB)) c.rx = ~c.rx;
        c.rstN = !(f.rstAt >= 0 && idx >= f.rstAt && idx < f.rstAt + 2);
        if (f.cfgScramble && b >= 1) begin
          c.parEn  = 1'($urandom_range(0, 1));
          c.parTyp = 1'($urandom_range(0, 1));
          c.presc  = 6'($urandom_range(0, 63));
        end else begin
          c.parEn  = f.parEn;
          c.parTyp = f.parTyp;
          c.presc  = 6'(p);
        end
        wave.push_back(c);
      end
    end

    if (f.rstAt >= 0) begin
      modelData = 8'h00;
      return;
    end
    if (!(p == 8 || p == 16 || p == 32)) return;

    // Each bit is the majority of the line at the three centre samples.
    for (int b = 0; b < nBits; b++) begin
      ones = 0;
      for (int k = -1; k <= 1; k++) ones += int'(wave[start + b * p + p / 2 + k].rx);
      recv.push_back(ones >= 2);
    end
    for (int i = 0; i < 8; i++) d[i] = recv[1 + i];
    recvPar  = f.parEn ? recv[9] : 1'b0;
    recvStop = recv[nBits - 1];
    parErr   = f.parEn && (recvPar != ((^d) ^ f.parTyp));
    stopErr  = !recvStop;

    if (parErr) expPeTime.push_back(start + nBits * p - 1);
    if (stopErr) expSeTime.push_back(start + nBits * p - 1);
    if (parErr || stopErr) begin
      expErrData.push_back(modelData);
    end else begin
      expDvTime.push_back(start + nBits * p - 1);
      expDvData.push_back(d);
      modelData = d;
    end
  endtask

  task automatic recordOutputs(input int k);
    if (busIf.data_valid === 1'b1) begin
      obsDvTime.push_back(k);
      obsDvData.push_back(busIf.P_DATA);
    end
    if (busIf.parity_error === 1'b1) obsPeTime.push_back(k);
    if (busIf.stop_error === 1'b1) obsSeTime.push_back(k);
    if (busIf.parity_error === 1'b1 || busIf.stop_error === 1'b1) obsErrData.push_back(busIf.P_DATA);
  endtask

  // Drives the prepared waveform one cycle per negedge and records outputs.
  task automatic applyStimulus();
    obsDvTime.delete();
    obsDvData.delete();
    obsPeTime.delete();
    obsSeTime.delete();
    obsErrData.delete();
    for (int c = 0; c < wave.size(); c++) begin
      @(negedge clk);
      if (c > 0) recordOutputs(c - 1);
      rstN           = wave[c].rstN;
      busIf.RX_IN    = wave[c].rx;
      busIf.PAR_EN   = wave[c].parEn;
      busIf.PAR_TYP  = wave[c].parTyp;
      busIf.Prescale = wave[c].presc;
    end
    @(negedge clk);
    recordOutputs(wave.size() - 1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkPhase(input string tag);
    checkOutput($sformatf("%s dv count", tag), obsDvTime.size(), expDvTime.size());
    for (int i = 0; i < expDvTime.size() && i < obsDvTime.size(); i++) begin
      checkOutput($sformatf("%s dv[%0d] cycle", tag, i), obsDvTime[i], expDvTime[i]);
      checkOutput($sformatf("%s dv[%0d] data", tag, i), obsDvData[i], expDvData[i]);
    end
    checkOutput($sformatf("%s parity_error count", tag), obsPeTime.size(), expPeTime.size());
    for (int i = 0; i < expPeTime.size() && i < obsPeTime.size(); i++)
      checkOutput($sformatf("%s parity_error[%0d] cycle", tag, i), obsPeTime[i], expPeTime[i]);
    checkOutput($sformatf("%s stop_error count", tag), obsSeTime.size(), expSeTime.size());
    for (int i = 0; i < expSeTime.size() && i < obsSeTime.size(); i++)
      checkOutput($sformatf("%s stop_error[%0d] cycle", tag, i), obsSeTime[i], expSeTime[i]);
    for (int i = 0; i < expErrData.size() && i < obsErrData.size(); i++)
      checkOutput($sformatf("%s P_DATA held on error[%0d]", tag, i), obsErrData[i], expErrData[i]);
    checkOutput($sformatf("%s final P_DATA", tag), busIf.P_DATA, modelData);
  endtask

  initial begin
    frame_t f;
    int     presc;
    int     t0;

    rstN           = 1'b0;
    busIf.RX_IN    = 1'b1;
    busIf.PAR_EN   = 1'b0;
    busIf.PAR_TYP  = 1'b0;
    busIf.Prescale = 6'd8;
    modelData      = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset P_DATA", busIf.P_DATA, 8'h00);
    checkOutput("reset data_valid", busIf.data_valid, 1'b0);
    checkOutput("reset parity_error", busIf.parity_error, 1'b0);
    checkOutput("reset stop_error", busIf.stop_error, 1'b0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, P=8, 0xA5: result seen at edge T0+80
    clearPhase();
    appendIdle(2, 8);
    t0 = wave.size();
    appendFrame(mkFrame(8'hA5, 1'b0, 1'b0, 8));
    appendIdle(4, 8);
    applyStimulus();
    checkPhase("8N1 P8 A5");
    checkOutput("8N1 P8 latency", (obsDvTime.size() > 0) ? obsDvTime[0] + 1 - t0 : -1, 80);

    // 8E1, P=16, 0x3C good then with corrupted parity bit
    clearPhase();
    appendIdle(2, 16);
    appendFrame(mkFrame(8'h3C, 1'b1, 1'b0, 16));
    appendIdle(3, 16);
    f = mkFrame(8'h3C, 1'b1, 1'b0, 16);
    f.parFlip = 1'b1;
    appendFrame(f);
    appendIdle(4, 16);
    applyStimulus();
    checkPhase("8E1 P16 3C");

    // Stop bit low on 0x5A, then a clean 0x81
    clearPhase();
    appendIdle(2, 8);
    f = mkFrame(8'h5A, 1'b0, 1'b0, 8);
    f.stopBit = 1'b0;
    appendFrame(f);
    appendIdle(3, 8);
    appendFrame(mkFrame(8'h81, 1'b0, 1'b0, 8));
    appendIdle(4, 8);
    applyStimulus();
    checkPhase("stop error");

    // False start (4 low cycles), new start right after edge 10, then an
    // unsupported ratio that must be ignored, then a good frame
    clearPhase();
    appendIdle(2, 16);
    for (int i = 0; i < 11; i++) begin
      cycle_t c;
      c.rx     = (i >= 4);
      c.rstN   = 1'b1;
      c.parEn  = 1'b0;
      c.parTyp = 1'b0;
      c.presc  = 6'd16;
      wave.push_back(c);
    end
    appendFrame(mkFrame(8'h00, 1'b0, 1'b0, 16));
    appendIdle(3, 16);
    appendFrame(mkFrame(8'h55, 1'b0, 1'b0, 12));
    appendIdle(20, 12);
    appendFrame(mkFrame(8'h6E, 1'b0, 1'b0, 16));
    appendIdle(4, 16);
    applyStimulus();
    checkPhase("false start");

    // Noise on data bit 3 of 0xFF at P=16
    clearPhase();
    appendIdle(2, 16);
    f = mkFrame(8'hFF, 1'b0, 1'b0, 16);
    f.noiseBit   = 4;
    f.noiseEdgeA = 8;
    appendFrame(f);
    appendIdle(3, 16);
    f.noiseEdgeA = 7;
    f.noiseEdgeB = 8;
    appendFrame(f);
    appendIdle(4, 16);
    applyStimulus();
    checkPhase("noise");
    checkOutput("noise two-cycle byte", (obsDvData.size() > 1) ? 32'(obsDvData[1]) : 32'hFFFF, 8'hF7);

    // Back-to-back 8O1 at P=32, then reset during a third frame
    clearPhase();
    appendIdle(2, 32);
    appendFrame(mkFrame(8'h12, 1'b1, 1'b1, 32));
    appendFrame(mkFrame(8'h34, 1'b1, 1'b1, 32));
    appendIdle(5, 32);
    f = mkFrame(8'hFF, 1'b1, 1'b1, 32);
    f.rstAt = 32 * 4 + 10;
    appendFrame(f);
    appendIdle(6, 32);
    applyStimulus();
    checkPhase("back-to-back");
    checkOutput("back-to-back spacing",
                (obsDvTime.size() > 1) ? obsDvTime[1] - obsDvTime[0] : -1, 352);
    checkOutput("after reset data_valid", busIf.data_valid, 1'b0);

    // Randomized frames with mid-frame configuration changes and noise
    clearPhase();
    appendIdle(2, 8);
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2))
        0:       presc = 8;
        1:       presc = 16;
        default: presc = 32;
      endcase
      f = mkFrame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), presc);
      f.parFlip     = ($urandom_range(0, 3) == 0);
      f.stopBit     = ($urandom_range(0, 4) != 0);
      f.cfgScramble = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        f.noiseBit   = $urandom_range(1, 8);
        f.noiseEdgeA = $urandom_range(0, presc - 1);
        f.noiseEdgeB = ($urandom_range(0, 1) == 1) ? $urandom_range(0, presc - 1) : -1;
      end
      appendFrame(f);
      appendIdle($urandom_range(0, 3), presc);
    end
    appendIdle(4, 8);
    applyStimulus();
    checkPhase("random");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
